mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; all values below assume WIDTH=32.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (reset=0 resets immediately, independent of clock).
REQ-004 The block SHALL have port multiplicand, input, 32, operand A, sampled only on a start cycle.
REQ-005 The block SHALL have port multiplier, input, 32, operand B, sampled only on a start cycle.
REQ-006 The block SHALL have port is_signed, input, 1, where 1 treats A/B as two's complement and 0 as unsigned; sampled only on a start cycle.
REQ-007 The block SHALL have port start, input, 1, a one-cycle request to begin a multiply.
REQ-008 The block SHALL have port hi, output, 32, upper half of the 64-bit product.
REQ-009 The block SHALL have port lo, output, 32, lower half of the 64-bit product.
REQ-010 The block SHALL have port busy, output, 1, high while iterating.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when the result becomes valid.

Function
REQ-012 On a rising edge with start=1, the block SHALL capture |A| and |B| (magnitudes if is_signed=1, raw values otherwise), a negate flag = is_signed & (A[31]^B[31]), clear the 33-bit accumulator, clear the iteration counter, and set busy=1.
REQ-013 A start=1 while busy=1 SHALL abort the current operation and restart with the new operands, exactly as in REQ-012.
REQ-014 While busy=1 and start=0, each edge SHALL perform one radix-2 shift-add step: if the product-register LSB=1, add |A| to the upper 33-bit accumulator; then shift the 65-bit {carry, upper, lower} register right by one bit.
REQ-015 The counter SHALL be 6 bits and increment once per step; on the edge where counter==31, the final step SHALL execute and busy SHALL clear.
REQ-016 Latency: with start sampled at edge E0, busy SHALL be high from E0 to E32, and done SHALL be high for exactly one cycle, from E32 to E33.
REQ-017 The value done SHALL equal busy_delayed & ~busy, with busy_delayed a register copy of busy, and SHALL never be high for two consecutive cycles.
REQ-018 Output {hi,lo} SHALL equal the 64-bit magnitude product, two's-complement negated when the negate flag is set; negation SHALL be combinational on the outputs and SHALL add no cycle.
REQ-019 Outputs hi and lo SHALL be valid from the done cycle and SHALL hold until the next start; values while busy=1 are unspecified.
REQ-020 Signed operands of 0x80000000 SHALL be handled as magnitude 2^31 without overflow.
REQ-021 A zero operand SHALL still take the full 32 steps; there is no early termination.
REQ-022 If start is high for several consecutive cycles, each one SHALL be a restart, and busy SHALL fall 32 edges after the last start edge.

Reset
REQ-023 While reset=0, the block SHALL force busy=0, busy_delayed=0, done=0, counter=0, product register=0 and negate flag=0, so that hi=0 and lo=0.
REQ-024 A reset asserted mid-operation SHALL discard the operation with no done pulse; after release, the block SHALL be idle until the next start.
REQ-025 The first start on the first rising edge after reset release SHALL be accepted.

Verification
REQ-026 The bench SHALL cover: unsigned 7 x 6, start at E0 -> busy high E0..E32, done pulse E32..E33, hi=0x00000000, lo=0x0000002A.
REQ-027 The bench SHALL cover: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with is_signed=1 -> hi=0x00000000, lo=0x00000001.
REQ-028 The bench SHALL cover: signed -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-029 The bench SHALL cover: start 2 x 3, then at step 10 start 4 x 5 -> no done for the first operation, a single done 32 edges after the second start, lo=0x00000014.
REQ-030 The bench SHALL cover: reset=0 at step 10 of 9 x 9 -> busy=0, done=0, hi=lo=0 immediately and no later done; after release, start 9 x 9 -> lo=0x00000051.
REQ-031 The bench SHALL cover: after a done, hold start=0 for 100 cycles and change the operand inputs -> hi/lo unchanged, busy=0, no further done.

Source files
------------

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: 32 steps after start, done pulses 32 edges after the start edge.
// No backpressure: a start at any time aborts and restarts; the result holds until the next start.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               is_signed,
    input  logic               start,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_busy_d;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_prod_next;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_result;

    // Negating the most negative value yields the same bit pattern, read here as unsigned 2^(WIDTH-1).
    assign w_a_abs = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_b_abs = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

    assign w_addend    = r_prod[0] ? {1'b0, r_mcand} : '0;
    assign w_sum       = r_prod[2*WIDTH:WIDTH] + w_addend;
    assign w_prod_next = {1'b0, w_sum, r_prod[WIDTH-1:1]};

    assign w_mag    = r_prod[2*WIDTH-1:0];
    assign w_result = r_neg ? -w_mag : w_mag;

    assign hi   = w_result[2*WIDTH-1:WIDTH];
    assign lo   = w_result[WIDTH-1:0];
    assign busy = r_busy;
    assign done = r_busy_d & ~r_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_busy_d <= 1'b0;
        end else begin
            r_busy_d <= r_busy;
            if (start) begin
                r_mcand <= w_a_abs;
                r_prod  <= {{(WIDTH+1){1'b0}}, w_b_abs};
                r_neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + CW'(1);
                if (r_cnt == LAST_STEP) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq with a result scoreboard checked on each done pulse.
module tb_mult_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        is_signed = 1'b0;
    logic        start = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];

    mult_seq #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .start        (start),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        return s ? 64'(sa * sbv) : ua * ub;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives a one-cycle start; the edge consumed here is E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        sb_q.delete();
        sb_q.push_back(model(a, b, s));
        tick();
        start = 1'b0;
        check64("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic await_done(input string tag);
        int n;
        int busy_cnt;
        logic [63:0] exp;
        n = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cnt++;
        end
        check64({tag, "_latency"}, 64'(n), 64'd32);
        check64({tag, "_busy_window"}, 64'(busy_cnt), 64'd31);
        check64({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        check64({tag, "_sb_pending"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check64({tag, "_result"}, {hi, lo}, exp);
        end
        tick();
        check64({tag, "_done_single"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int dones;
        int busies;

        // Reset state
        #3;
        check64("reset_busy", {63'b0, busy}, 64'd0);
        check64("reset_done", {63'b0, done}, 64'd0);
        check64("reset_hilo", {hi, lo}, 64'd0);
        tick();
        tick();
        reset = 1'b1;

        issue(32'd7, 32'd6, 1'b0);
        await_done("u7x6");
        check64("u7x6_lo_const", {hi, lo}, 64'h0000_0000_0000_002A);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        await_done("u_max");
        check64("u_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        await_done("s_m1");
        check64("s_m1_const", {hi, lo}, 64'h0000_0000_0000_0001);

        issue(32'hFFFF_FFFD, 32'd5, 1'b1);
        await_done("s_m3x5");
        check64("s_m3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        await_done("s_min");
        check64("s_min_const", {hi, lo}, 64'h4000_0000_0000_0000);

        issue(32'd12345, 32'hFFFF_FF00, 1'b1);
        await_done("s_mixed");

        issue(32'd0, 32'hDEAD_BEEF, 1'b0);
        await_done("zero_op");

        // Abort by restart at step 10
        issue(32'd2, 32'd3, 1'b0);
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        issue(32'd4, 32'd5, 1'b0);
        check64("restart_no_early_done", 64'(dones), 64'd0);
        await_done("restart");
        check64("restart_lo", {32'b0, lo}, 64'h14);

        // Back-to-back starts: only the last one counts
        sb_q.delete();
        is_signed = 1'b0;
        start = 1'b1;
        multiplicand = 32'd1; multiplier = 32'd1;
        tick();
        multiplicand = 32'd2; multiplier = 32'd2;
        tick();
        multiplicand = 32'd3; multiplier = 32'd3;
        sb_q.push_back(model(32'd3, 32'd3, 1'b0));
        tick();
        start = 1'b0;
        await_done("multi_start");

        // Reset mid-operation
        issue(32'd9, 32'd9, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        sb_q.delete();
        check64("midrst_busy", {63'b0, busy}, 64'd0);
        check64("midrst_done", {63'b0, done}, 64'd0);
        check64("midrst_hilo", {hi, lo}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        dones = 0;
        busies = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
        end
        check64("midrst_no_done", 64'(dones), 64'd0);
        check64("midrst_idle", 64'(busies), 64'd0);

        // Start on the first edge after reset release
        reset = 1'b0;
        tick();
        reset = 1'b1;
        issue(32'd9, 32'd9, 1'b0);
        await_done("post_rst");
        check64("post_rst_lo", {32'b0, lo}, 64'h51);

        // Hold after done while inputs move
        dones = 0;
        busies = 0;
        for (int i = 0; i < 100; i++) begin
            multiplicand = $urandom;
            multiplier   = $urandom;
            is_signed    = 1'($urandom_range(0, 1));
            tick();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
        end
        check64("hold_hilo", {hi, lo}, 64'h51);
        check64("hold_no_done", 64'(dones), 64'd0);
        check64("hold_idle", 64'(busies), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
